// File: rtl/delay_scheduler.sv
// rtl/delay_scheduler.sv - round-robin arbiter for N requesters sharing one delay timer.
// Optional WAIT timeout with err output: define DELAY_SCHED_TIMEOUT_EN.
module delay_scheduler #(
    parameter int N             = 4,
    parameter int COUNTER_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req,
    input  logic [N*COUNTER_WIDTH-1:0] req_len,
    output logic                       timer_start,
    output logic [COUNTER_WIDTH-1:0]   timer_max,
    input  logic                       timer_done,
    output logic [N-1:0]               grant,
    output logic [N-1:0]               ack,
`ifdef DELAY_SCHED_TIMEOUT_EN
    output logic                       err,
`endif
    output logic                       busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            last_q, last_d;
    logic [N-1:0]             grant_q, grant_d;
    logic [N-1:0]             ack_q, ack_d;
    logic                     start_q, start_d;
    logic                     busy_q, busy_d;
    logic [COUNTER_WIDTH-1:0] max_q, max_d;
    logic [COUNTER_WIDTH-1:0] lens [N];
    logic                     found;
    logic [IW-1:0]            pick;
    logic [IW-1:0]            cand;

`ifdef DELAY_SCHED_TIMEOUT_EN
    logic [COUNTER_WIDTH+3:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH+3:0] cnt_inc;
    logic [COUNTER_WIDTH+3:0] cnt_limit;
    logic                     err_q, err_d;
`endif

    for (genvar g = 0; g < N; g++) begin : g_len
        assign lens[g] = req_len[g*COUNTER_WIDTH +: COUNTER_WIDTH];
    end

    always_comb begin
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        ack_d   = '0;
        max_d   = max_q;
`ifdef DELAY_SCHED_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_inc   = cnt_q + 1'b1;
        cnt_limit = {4'b0000, max_q} + (COUNTER_WIDTH+4)'(8);
        cnt_d     = (state_q == ST_WAIT) ? cnt_inc : '0;
`endif

        // Search upward from the requester after the previous winner, wrapping once.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_q) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d       = ST_START;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    last_d        = pick;
                    max_d         = lens[pick];
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (timer_done) begin
                    state_d = ST_ACK;
                    ack_d   = grant_q;
                end
`ifdef DELAY_SCHED_TIMEOUT_EN
                else if (cnt_inc == cnt_limit) begin
                    state_d = ST_ACK;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(N - 1);
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            max_q   <= max_d;
        end
    end

`ifdef DELAY_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign timer_start = start_q;
    assign timer_max   = max_q;
    assign grant       = grant_q;
    assign ack         = ack_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// tb/tb_delay_scheduler.sv - self-checking bench for delay_scheduler with a transaction-level model.
module tb_delay_scheduler;

    localparam int N  = 4;
    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] req_len = '0;
    logic            timer_start;
    logic [CW-1:0]   timer_max;
    logic            timer_done;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            busy;
`ifdef DELAY_SCHED_TIMEOUT_EN
    logic            err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    delay_scheduler #(.N(N), .COUNTER_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .timer_start(timer_start),
        .timer_max  (timer_max),
        .timer_done (timer_done),
        .grant      (grant),
        .ack        (ack),
`ifdef DELAY_SCHED_TIMEOUT_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Delay timer: pulses done tm_delay cycles after it sees timer_start, plus manual injection.
    int   tm_cnt   = 0;
    bit   tm_auto  = 0;
    int   tm_delay = 7;
    logic tm_pulse = 1'b0;
    logic inject   = 1'b0;
    assign timer_done = tm_pulse | inject;

    always @(negedge clk) begin
        tm_pulse = 1'b0;
        if (tm_cnt > 0) begin
            tm_cnt--;
            if (tm_cnt == 0) tm_pulse = 1'b1;
        end
        if (tm_auto && timer_start === 1'b1) tm_cnt = tm_delay;
    end

    // Model: current owner (-1 idle), cycles since grant, latched length, ack phase.
    int            m_owner  = -1;
    int            m_last   = N - 1;
    int            m_age    = 0;
    logic [CW-1:0] m_max    = '0;
    bit            m_acking = 0;
    bit            m_err    = 0;
    bit            mf;
    int            cyc      = 0;
    int            done_cyc = -1;

    always @(posedge clk) begin
        if (timer_done === 1'b1) done_cyc = cyc;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_age = 0; m_max = '0; m_acking = 0; m_err = 0;
        end else if (m_owner < 0) begin
            mf = 0;
            for (int k = 1; k <= N; k++) begin
                if (!mf && req[(m_last + k) % N]) begin
                    mf = 1;
                    m_owner = (m_last + k) % N;
                end
            end
            if (mf) begin
                m_last = m_owner;
                m_max  = req_len[m_owner*CW +: CW];
                m_age  = 1;
            end
        end else if (m_acking) begin
            m_owner = -1; m_acking = 0; m_err = 0;
        end else begin
            if (m_age >= 2 && timer_done === 1'b1) m_acking = 1;
`ifdef DELAY_SCHED_TIMEOUT_EN
            else if (m_age >= 2 && (m_age - 1) == int'(m_max) + 8) begin
                m_acking = 1; m_err = 1;
            end
`endif
            m_age++;
        end
        cyc++;
    end

    logic [N-1:0] eg, ea;
    logic [N-1:0] prev_grant = '0;
    int           ack_cnt    = 0;
    logic [N-1:0] glog[$];
    int           gack[$];

    always @(negedge clk) begin
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        ea = m_acking ? eg : '0;
        chk("grant", grant, eg);
        chk("ack", ack, ea);
        chk("timer_start", timer_start, (m_owner >= 0 && m_age == 1));
        chk("busy", busy, (m_owner >= 0));
        chk("timer_max", timer_max, m_max);
`ifdef DELAY_SCHED_TIMEOUT_EN
        chk("err", err, m_err && m_acking);
`endif
        if (ack !== '0) ack_cnt++;
        if (grant !== '0 && prev_grant === '0) begin
            glog.push_back(grant);
            gack.push_back(ack_cnt);
        end
        prev_grant = grant;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string name, output int at);
        bit got = 0;
        at = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (timer_start === 1'b1) begin got = 1; at = cyc; end
        end
        chk(name, got, 1);
    endtask

    task automatic wait_ack(input string name, output int at);
        bit got = 0;
        at = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (ack !== '0) begin got = 1; at = cyc; end
        end
        chk(name, got, 1);
    endtask

    logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int c0, s_at, a_at, base, a0;

    initial begin
        rst = 1'b1;
        tick(3);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_max", timer_max, 0);
        chk("rst_ack", ack, 0);
        rst = 1'b0;

        // Single request, timer answers 7 cycles after start.
        tm_auto = 1; tm_delay = 7;
        req_len[0 +: CW] = 10'd5;
        req = 4'b0001;
        c0 = cyc;
        wait_start("s1_start_seen", s_at);
        chk("s1_start_lat", s_at, c0 + 1);
        chk("s1_max", timer_max, 5);
        chk("s1_grant", grant, 4'b0001);
        wait_ack("s1_ack_seen", a_at);
        req = '0;
        chk("s1_ack_val", ack, 4'b0001);
        chk("s1_done_lat", done_cyc, s_at + 7);
        chk("s1_ack_lat", a_at, s_at + 8);
        tick(2);

        // All four held after reset: 0,1,2,3,0.
        rst = 1'b1; tick(1); rst = 1'b0;
        for (int i = 0; i < N; i++) req_len[i*CW +: CW] = CW'(i + 1);
        tm_delay = 3;
        base = glog.size();
        req = 4'b1111;
        for (int k = 0; k < 400 && glog.size() < base + 5; k++) tick(1);
        req = '0;
        chk("s2_grant_count", (glog.size() >= base + 5), 1);
        if (glog.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("s2_rr_order", glog[base+k], exp_rr[k]);
                chk("s2_ack_before_grant", gack[base+k] - gack[base], k);
            end
        end
        wait_ack("s2_last_ack", a_at);
        tick(2);

        // After requester 2 wins, 0101 wraps to requester 0.
        req = 4'b0100;
        wait_ack("s3_ack2_seen", a_at);
        chk("s3_ack2", ack, 4'b0100);
        req = 4'b0101;
        base = glog.size();
        wait_start("s3_start", s_at);
        chk("s3_wrap_grant", grant, 4'b0001);
        wait_ack("s3_ack0", a_at);
        req = '0;
        tick(2);

        // Stray done in IDLE and START, len change and req drop during WAIT.
        tm_auto = 0;
        inject = 1'b1; tick(1); inject = 1'b0; tick(1);
        chk("s4_idle_done_ignored", busy, 0);
        req_len[1*CW +: CW] = 10'd3;
        req = 4'b0010;
        wait_start("s4_start", s_at);
        inject = 1'b1; tick(1); inject = 1'b0;
        chk("s4_start_done_ignored", busy, 1);
        req_len[1*CW +: CW] = 10'd9;
        req = '0;
        tick(3);
        chk("s4_max_hold", timer_max, 3);
        chk("s4_grant_hold", grant, 4'b0010);
        inject = 1'b1; tick(1); inject = 1'b0;
        chk("s4_ack_after_drop", ack, 4'b0010);
        tick(2);

        // Zero length is forwarded unchanged.
        req_len[3*CW +: CW] = '0;
        tm_auto = 1; tm_delay = 1;
        req = 4'b1000;
        wait_start("s4_zero_start", s_at);
        chk("s4_zero_len", timer_max, 0);
        wait_ack("s4_zero_ack", a_at);
        req = '0;
        tick(2);

        // Reset in WAIT drops the transaction; a late done is ignored.
        tm_auto = 0;
        req_len[0 +: CW] = 10'd6;
        req = 4'b0001;
        wait_start("s5_start", s_at);
        tick(2);
        rst = 1'b1; tick(1); rst = 1'b0;
        req = '0;
        chk("s5_grant", grant, 0);
        chk("s5_busy", busy, 0);
        chk("s5_max", timer_max, 0);
        chk("s5_start", timer_start, 0);
        a0 = ack_cnt;
        inject = 1'b1; tick(1); inject = 1'b0;
        tick(3);
        chk("s5_no_ack", ack_cnt, a0);
        chk("s5_idle", busy, 0);

`ifdef DELAY_SCHED_TIMEOUT_EN
        // No done ever: 12 WAIT cycles then ack with err.
        tm_auto = 0;
        req_len[0 +: CW] = 10'd4;
        req = 4'b0001;
        wait_start("s6_start", s_at);
        wait_ack("s6_ack_seen", a_at);
        chk("s6_timeout_lat", a_at, s_at + 13);
        chk("s6_err", err, 1);
        chk("s6_ack", ack, 4'b0001);
        req = '0;
        tick(2);
        chk("s6_idle", busy, 0);
        chk("s6_err_clear", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
